mem_port_scheduler: RTL and testbench

- Shares one single-ported memory interface among NUM_CLIENTS requesters, e.g. hash cores and the host DMA.
- Arbitration is round-robin. The grant is locked for the whole multi-beat burst.
- The block generates per-beat addresses and write data, returns read data to the owner, and pulses a per-client done at burst end.
- Sits between the compute clients and the shared scratchpad RAM.

---
 rtl/mem_port_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_port_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler
// Shares one single-ported memory among NUM_CLIENTS requesters. Each
// requester asks for a multi-beat burst. A round-robin arbiter picks the
// owner, and the grant stays locked until the burst has finished.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   req_valid       per-client request, held until that client's done
//   req_write       per-client burst direction (1 = write, 0 = read)
//   req_addr        per-client burst base word address (packed slices)
//   req_len         per-client beat count (packed slices, 0 means 1)
//   req_wdata       per-client current write beat (packed slices)
//   grant           one-hot burst owner (registered)
//   beat_ack        one-hot, memory accepted the owner's beat this cycle
//   rd_valid        one-hot, rd_data is valid for that client (registered)
//   rd_data         registered read data
//   done            one-cycle pulse to the owner at burst end (registered)
//   busy            scheduler is not idle
//   mem_en/mem_wr   memory access request / write strobe
//   mem_addr        memory word address
//   mem_wdata       memory write data
//   mem_rdata       memory read data, valid while mem_ready=1
//   mem_ready       memory accepts the current access this cycle
module mem_port_scheduler #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            req_valid,
  input  logic [NUM_CLIENTS-1:0]            req_write,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CLIENTS*LEN_WIDTH-1:0]  req_len,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_CLIENTS-1:0]            grant,
  output logic [NUM_CLIENTS-1:0]            beat_ack,
  output logic [NUM_CLIENTS-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic [NUM_CLIENTS-1:0]            done,
  output logic                              busy,
  output logic                              mem_en,
  output logic                              mem_wr,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  input  logic                              mem_ready
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       owner;
  logic                   wr_flag;
  logic [ADDR_WIDTH-1:0]  base;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beat;

  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_CLIENTS-1:0] pick_grant;
  logic                   pick_wr;
  logic [ADDR_WIDTH-1:0]  pick_addr;
  logic [LEN_WIDTH-1:0]   pick_len;
  int                     rot_idx;

  logic                   last_beat;
  logic                   accept;
  logic [IDX_W-1:0]       ptr_next;

  // Round-robin search: the first requesting client at or above ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rot_idx    = 0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      rot_idx = (int'(ptr) + k >= NUM_CLIENTS) ? (int'(ptr) + k - NUM_CLIENTS)
                                               : (int'(ptr) + k);
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (!pick_found && (i == rot_idx) && req_valid[i]) begin
          pick_found = 1'b1;
          pick_idx   = IDX_W'(i);
        end else begin
          pick_found = pick_found;
        end
      end
    end
  end

  // Select the chosen client's burst descriptor.
  always_comb begin
    pick_grant = '0;
    pick_wr    = 1'b0;
    pick_addr  = '0;
    pick_len   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_found && (pick_idx == IDX_W'(i))) begin
        pick_grant[i] = 1'b1;
        pick_wr       = req_write[i];
        pick_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_len      = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end else begin
        pick_grant[i] = 1'b0;
      end
    end
  end

  // Beat bookkeeping and the pointer value used once the burst retires.
  always_comb begin
    accept    = (state == ST_BURST) && mem_ready;
    last_beat = (beat == (len_q - LEN_WIDTH'(1)));
    if (owner == IDX_W'(NUM_CLIENTS - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = owner + IDX_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_next = ST_BURST;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (accept && last_beat) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_BURST;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, grant lock, burst descriptor latch and registered client outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      owner    <= '0;
      wr_flag  <= 1'b0;
      base     <= '0;
      len_q    <= '0;
      beat     <= '0;
      grant    <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
      done     <= '0;
    end else begin
      state    <= state_next;
      rd_valid <= '0;
      done     <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant   <= pick_grant;
            owner   <= pick_idx;
            wr_flag <= pick_wr;
            base    <= pick_addr;
            // A zero length would otherwise never reach its last beat.
            len_q   <= (pick_len == '0) ? LEN_WIDTH'(1) : pick_len;
            beat    <= '0;
          end else begin
            grant   <= '0;
          end
        end
        ST_BURST: begin
          if (mem_ready) begin
            beat <= beat + LEN_WIDTH'(1);
            if (!wr_flag) begin
              rd_data  <= mem_rdata;
              rd_valid <= grant;
            end
            // Registered so done lands together with the last rd_valid.
            if (last_beat) begin
              done <= grant;
            end
          end
        end
        ST_DONE: begin
          ptr   <= ptr_next;
          grant <= '0;
        end
        default: begin
          grant <= '0;
        end
      endcase
    end
  end

  // Memory-side signals are decoded from registered state, so they hold
  // steady across mem_ready stalls.
  always_comb begin
    busy      = (state != ST_IDLE);
    mem_en    = (state == ST_BURST);
    mem_wr    = mem_en && wr_flag;
    mem_addr  = '0;
    mem_wdata = '0;
    beat_ack  = '0;
    if (mem_en) begin
      // Address arithmetic wraps at 2^ADDR_WIDTH.
      mem_addr = base + ADDR_WIDTH'(beat);
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (grant[i]) begin
          mem_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          mem_wdata = mem_wdata;
        end
      end
      if (mem_ready) begin
        beat_ack = grant;
      end else begin
        beat_ack = '0;
      end
    end else begin
      mem_addr = '0;
    end
  end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Scoreboard bench for mem_port_scheduler: expected grants, memory beats,
// read returns and done pulses are queued as stimulus is issued and are
// popped as the design produces them.
module tb_mem_port_scheduler;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    grant, beat_ack, rd_valid, done;
  logic [DW-1:0]   rd_data, mem_wdata, mem_rdata;
  logic            busy, mem_en, mem_wr, mem_ready;
  logic [AW-1:0]   mem_addr;

  mem_port_scheduler #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .grant(grant), .beat_ack(beat_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .busy(busy), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: read data is the word address plus 0x100.
  assign mem_rdata = {16'h0000, mem_addr} + 32'h0000_0100;

  typedef struct {int c; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata;} acc_t;
  typedef struct {int c; logic wr; int len;} brs_t;
  typedef struct {int c; logic [DW-1:0] data;} rd_t;

  acc_t acc_q[$];
  rd_t  rd_q[$];
  brs_t gnt_q[$];
  int   done_q[$];

  int checks   = 0;
  int failures = 0;
  int rem[N];
  int wbeat[N];
  logic [N-1:0] done_s, ack_s;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] wpat(input int c, input int b);
    return 32'hA000_0000 + (32'(c) << 8) + 32'(b);
  endfunction

  function automatic logic [N-1:0] onehot(input int c);
    return N'(1) << c;
  endfunction

  task automatic start_client(input int c, input logic wr, input logic [AW-1:0] addr,
                              input logic [LW-1:0] len, input int n);
    req_write[c]           = wr;
    req_addr[c*AW +: AW]   = addr;
    req_len[c*LW +: LW]    = len;
    rem[c]                 = n;
    wbeat[c]               = 0;
    req_wdata[c*DW +: DW]  = wpat(c, 0);
    req_valid[c]           = 1'b1;
  endtask

  task automatic push_burst(input int c, input logic wr, input logic [AW-1:0] addr, input int len);
    int l;
    logic [AW-1:0] a;
    l = (len == 0) ? 1 : len;
    gnt_q.push_back('{c, wr, l});
    for (int b = 0; b < l; b++) begin
      a = addr + AW'(b);
      acc_q.push_back('{c, wr, a, wr ? wpat(c, b) : 32'h0});
      if (!wr) rd_q.push_back('{c, {16'h0000, a} + 32'h0000_0100});
    end
    done_q.push_back(c);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < bound) begin
      @(negedge clk);
      n++;
      ok = !busy && (req_valid == '0) && (acc_q.size() == 0) && (gnt_q.size() == 0)
           && (done_q.size() == 0) && (rd_q.size() == 0);
    end
    check_eq("idle_reached", 64'(ok), 64'(1));
  endtask

  task automatic wait_grant(input int bound);
    int n;
    n = 0;
    while (grant == '0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq("grant_wait", 64'(grant != '0), 64'(1));
  endtask

  // Monitor: pops scoreboard entries as the design produces events.
  initial begin
    brs_t cur;
    acc_t a;
    rd_t  r;
    int   dc;
    int   acks;
    logic [N-1:0] prev_grant;
    cur = '{0, 1'b0, 0};
    acks = 0;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_grant = '0;
        done_s = '0;
        ack_s  = '0;
      end else begin
        done_s = done;
        ack_s  = beat_ack;
        if (grant != '0 && prev_grant == '0) begin
          check_eq("grant_expected", 64'(gnt_q.size() != 0), 64'(1));
          if (gnt_q.size() != 0) begin
            cur = gnt_q.pop_front();
            check_eq("grant", 64'(grant), 64'(onehot(cur.c)));
          end
          acks = 0;
        end
        if (mem_en && mem_ready) begin
          check_eq("beat_expected", 64'(acc_q.size() != 0), 64'(1));
          if (acc_q.size() != 0) begin
            a = acc_q.pop_front();
            check_eq("mem_addr", 64'(mem_addr), 64'(a.addr));
            check_eq("mem_wr", 64'(mem_wr), 64'(a.wr));
            check_eq("beat_ack", 64'(beat_ack), 64'(onehot(a.c)));
            if (a.wr) check_eq("mem_wdata", 64'(mem_wdata), 64'(a.wdata));
          end
          acks++;
        end else if (beat_ack != '0) begin
          check_eq("beat_ack_stray", 64'(beat_ack), 64'(0));
        end
        if (rd_valid != '0) begin
          check_eq("rd_expected", 64'(rd_q.size() != 0), 64'(1));
          if (rd_q.size() != 0) begin
            r = rd_q.pop_front();
            check_eq("rd_valid", 64'(rd_valid), 64'(onehot(r.c)));
            check_eq("rd_data", 64'(rd_data), 64'(r.data));
          end
        end
        if (done != '0) begin
          check_eq("done_expected", 64'(done_q.size() != 0), 64'(1));
          if (done_q.size() != 0) begin
            dc = done_q.pop_front();
            check_eq("done", 64'(done), 64'(onehot(dc)));
            check_eq("beats_per_burst", 64'(acks), 64'(cur.len));
            if (!cur.wr) check_eq("done_with_rd_valid", 64'(rd_valid), 64'(done));
          end
        end
        prev_grant = grant;
      end
    end
  end

  // Client model: advance write data on beat_ack, drop or renew at done.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          if (done_s[i]) begin
            wbeat[i] = 0;
            if (rem[i] > 0) rem[i] = rem[i] - 1;
            if (rem[i] == 0) req_valid[i] = 1'b0;
          end
          if (ack_s[i]) wbeat[i] = wbeat[i] + 1;
          req_wdata[i*DW +: DW] = wpat(i, wbeat[i]);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_len   = '0;
    req_wdata = '0;
    mem_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      rem[i]   = 0;
      wbeat[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_grant", 64'(grant), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_mem_en", 64'(mem_en), 64'(0));
    check_eq("rst_flags", 64'({done, rd_valid, beat_ack}), 64'(0));
    check_eq("rst_rd_data", 64'(rd_data), 64'(0));
    #1 rst = 1'b0;

    // Single-beat write with cycle-accurate latency checks.
    @(posedge clk); #2;
    start_client(0, 1'b1, 16'h0010, 4'd1, 1);
    push_burst(0, 1'b1, 16'h0010, 1);
    @(negedge clk);
    check_eq("t1_no_grant_yet", 64'(grant), 64'(0));
    @(negedge clk);
    check_eq("t1_grant", 64'(grant), 64'(4'b0001));
    check_eq("t1_mem_en", 64'({mem_en, mem_wr}), 64'(2'b11));
    check_eq("t1_addr", 64'(mem_addr), 64'(16'h0010));
    check_eq("t1_ack", 64'(beat_ack), 64'(4'b0001));
    @(negedge clk);
    check_eq("t1_done", 64'(done), 64'(4'b0001));
    check_eq("t1_done_mem_en", 64'(mem_en), 64'(0));
    check_eq("t1_done_grant", 64'(grant), 64'(4'b0001));
    @(negedge clk);
    check_eq("t1_after_grant", 64'(grant), 64'(0));
    check_eq("t1_after_busy", 64'(busy), 64'(0));
    wait_idle(50);

    // Read burst wrapping across the top of the address space.
    @(posedge clk); #2;
    start_client(2, 1'b0, 16'hFFFE, 4'd4, 1);
    push_burst(2, 1'b0, 16'hFFFE, 4);
    wait_idle(50);

    // Zero length is a single beat.
    @(posedge clk); #2;
    start_client(3, 1'b1, 16'h0400, 4'd0, 1);
    push_burst(3, 1'b1, 16'h0400, 0);
    wait_idle(50);

    // Round robin, all four clients, client 0 asks twice.
    @(posedge clk); #2;
    start_client(0, 1'b1, 16'h0500, 4'd1, 2);
    start_client(1, 1'b1, 16'h0501, 4'd1, 1);
    start_client(2, 1'b1, 16'h0502, 4'd1, 1);
    start_client(3, 1'b1, 16'h0503, 4'd1, 1);
    push_burst(0, 1'b1, 16'h0500, 1);
    push_burst(1, 1'b1, 16'h0501, 1);
    push_burst(2, 1'b1, 16'h0502, 1);
    push_burst(3, 1'b1, 16'h0503, 1);
    push_burst(0, 1'b1, 16'h0500, 1);
    wait_idle(200);

    // Only clients 1 and 3, client 1 asks twice.
    @(posedge clk); #2;
    start_client(1, 1'b1, 16'h0511, 4'd1, 2);
    start_client(3, 1'b1, 16'h0513, 4'd1, 1);
    push_burst(1, 1'b1, 16'h0511, 1);
    push_burst(3, 1'b1, 16'h0513, 1);
    push_burst(1, 1'b1, 16'h0511, 1);
    wait_idle(200);

    // Stall on beat 1 of a three-beat write.
    @(posedge clk); #2;
    start_client(1, 1'b1, 16'h0200, 4'd3, 1);
    push_burst(1, 1'b1, 16'h0200, 3);
    wait_grant(50);
    @(posedge clk); #2;
    mem_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check_eq("stall_addr", 64'(mem_addr), 64'(16'h0201));
      check_eq("stall_wdata", 64'(mem_wdata), 64'(wpat(1, 1)));
      check_eq("stall_ack_done", 64'({beat_ack, done}), 64'(0));
    end
    @(posedge clk); #2;
    mem_ready = 1'b1;
    wait_idle(50);

    // Reset during beat 2 of a four-beat write.
    @(posedge clk); #2;
    start_client(3, 1'b1, 16'h0600, 4'd4, 1);
    gnt_q.push_back('{3, 1'b1, 4});
    for (int b = 0; b < 3; b++) acc_q.push_back('{3, 1'b1, 16'h0600 + AW'(b), wpat(3, b)});
    wait_grant(50);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_mid_beat2", 64'(mem_addr), 64'(16'h0602));
    #1 rst = 1'b1;
    #1;
    check_eq("rst_mid_grant", 64'(grant), 64'(0));
    check_eq("rst_mid_mem_en", 64'(mem_en), 64'(0));
    check_eq("rst_mid_busy", 64'(busy), 64'(0));
    check_eq("rst_mid_done", 64'(done), 64'(0));
    req_valid[3] = 1'b0;
    rem[3]       = 0;
    wbeat[3]     = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_mid_queues", 64'(acc_q.size() + gnt_q.size() + done_q.size()), 64'(0));
    #1 rst = 1'b0;
    @(posedge clk); #2;
    start_client(1, 1'b1, 16'h0701, 4'd1, 1);
    start_client(3, 1'b1, 16'h0703, 4'd1, 1);
    push_burst(1, 1'b1, 16'h0701, 1);
    push_burst(3, 1'b1, 16'h0703, 1);
    wait_idle(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
